// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - registered pattern detector over a valid-qualified symbol stream
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset, highest priority
//   i_clear      synchronous soft clear of state, index, timer and match counter
//   i_valid      qualifies i_sym this cycle
//   i_sym        input symbol (SYM_W bits)
//   i_pattern    target pattern, symbol k at [k*SYM_W +: SYM_W], k=0 expected first
//   o_state      IDLE=0, MATCH=1, DONE=2
//   o_idx        pattern symbols matched so far
//   o_match      high for the single DONE cycle
//   o_timeout    one-cycle pulse following an idle-timeout abort
//   o_match_cnt  saturating count of completed matches
module seq_detector #(
  parameter int SYM_W   = 4,
  parameter int SEQ_LEN = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = $clog2(SEQ_LEN + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [SYM_W-1:0]         i_sym,
  input  logic [SEQ_LEN*SYM_W-1:0] i_pattern,
  output logic [1:0]               o_state,
  output logic [IDX_W-1:0]         o_idx,
  output logic                     o_match,
  output logic                     o_timeout,
  output logic [CNT_W-1:0]         o_match_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    DONE  = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_inc;
  logic [SYM_W-1:0] exp_sym;
  logic             hit_first;

  // Symbol expected at the current index, taken live from i_pattern.
  always_comb begin
    exp_sym = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (idx_q == IDX_W'(k)) exp_sym = i_pattern[k*SYM_W +: SYM_W];
    end
  end

  assign hit_first = i_valid && (i_sym == i_pattern[SYM_W-1:0]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = 8'd0;
    timeout_d = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = hit_first ? MATCH : IDLE;
        idx_d   = hit_first ? IDX_W'(1) : '0;
      end
      MATCH: begin
        if (i_valid) begin
          if (i_sym == exp_sym) begin
            if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
              state_d = DONE;
              idx_d   = IDX_W'(SEQ_LEN);
              cnt_inc = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (hit_first) begin
            // Only restart on the first pattern symbol; no deeper overlap search.
            idx_d = IDX_W'(1);
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          // This idle cycle brings the timer to TIMEOUT: abort the partial match.
          state_d   = IDLE;
          idx_d     = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      timer_q   <= 8'd0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_state     = state_q;
  assign o_idx       = idx_q;
  assign o_match     = (state_q == DONE);
  assign o_timeout   = timeout_q;
  assign o_match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - vector table, corner sequences and random model check for seq_detector
module tb_seq_detector;
  localparam int SYM_W   = 4;
  localparam int SEQ_LEN = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = $clog2(SEQ_LEN + 1);
  localparam logic [15:0] PAT = 16'h73AE;

  logic                     clk = 1'b0;
  logic                     rst, clr, valid;
  logic [SYM_W-1:0]         sym;
  logic [SEQ_LEN*SYM_W-1:0] pattern;
  logic [1:0]               st;
  logic [IDX_W-1:0]         idx;
  logic                     match, tout;
  logic [CNT_W-1:0]         cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_detector #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_valid(valid), .i_sym(sym),
    .i_pattern(pattern), .o_state(st), .o_idx(idx), .o_match(match),
    .o_timeout(tout), .o_match_cnt(cnt)
  );

  typedef struct {
    logic       rst, clr, v;
    logic [3:0] sym;
    logic [1:0] st;
    logic [2:0] idx;
    logic       m, to;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, c, v, input logic [3:0] s, input logic [1:0] es,
                              input logic [2:0] ei, input logic em, eto, input logic [7:0] ec);
    vec_t t;
    t.rst = r; t.clr = c; t.v = v; t.sym = s; t.st = es; t.idx = ei; t.m = em; t.to = eto; t.cnt = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] es, input logic [2:0] ei,
                           input logic em, eto, input logic [7:0] ec);
    check({tag, " state"}, 32'(st), 32'(es));
    check({tag, " idx"}, 32'(idx), 32'(ei));
    check({tag, " match"}, 32'(match), 32'(em));
    check({tag, " timeout"}, 32'(tout), 32'(eto));
    check({tag, " cnt"}, 32'(cnt), 32'(ec));
  endtask

  task automatic drive(input logic r, c, v, input logic [3:0] s);
    rst = r; clr = c; valid = v; sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pat();
    drive(0, 0, 1, 4'hE); drive(0, 0, 1, 4'hA); drive(0, 0, 1, 4'h3); drive(0, 0, 1, 4'h7);
  endtask

  // Behavioural model: progress count p (p==SEQ_LEN means the one-cycle done),
  // idle run length, saturating count.
  int m_p, m_idle, m_cnt;
  bit m_to;

  function automatic logic [3:0] psym(input logic [15:0] p, input int k);
    return p[k*4 +: 4];
  endfunction

  task automatic model_step(input logic r, c, v, input logic [3:0] s, input logic [15:0] p);
    m_to = 0;
    if (r || c) begin
      m_p = 0; m_idle = 0; m_cnt = 0;
    end else if (v) begin
      m_idle = 0;
      if (m_p > 0 && m_p < SEQ_LEN && s == psym(p, m_p)) begin
        m_p++;
        if (m_p == SEQ_LEN && m_cnt < 255) m_cnt++;
      end else begin
        m_p = (s == psym(p, 0)) ? 1 : 0;
      end
    end else if (m_p > 0 && m_p < SEQ_LEN) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_p = 0; m_idle = 0; m_to = 1;
      end
    end else begin
      m_p = 0; m_idle = 0;
    end
  endtask

  initial begin
    int pulses;
    int vprob;
    logic r, c, v;
    logic [3:0] s;
    rst = 1; clr = 0; valid = 0; sym = '0; pattern = PAT;

    // Table of single-cycle vectors: inputs then expected outputs after the edge.
    tbl.push_back(mk(1,0,0,4'h0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'h5, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hE, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,0));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,0));
    tbl.push_back(mk(0,0,1,4'h3, 1,3,0,0,0));
    tbl.push_back(mk(0,0,1,4'h7, 2,4,1,0,1));
    tbl.push_back(mk(0,0,0,4'h0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,1));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,1));
    tbl.push_back(mk(0,0,1,4'h3, 1,3,0,0,1));
    tbl.push_back(mk(0,0,1,4'h7, 2,4,1,0,2));
    tbl.push_back(mk(0,0,0,4'h0, 0,0,0,0,2));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,2));
    tbl.push_back(mk(0,0,1,4'h5, 0,0,0,0,2));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,2));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,2));
    tbl.push_back(mk(0,0,1,4'h3, 1,3,0,0,2));
    tbl.push_back(mk(0,0,1,4'h7, 2,4,1,0,3));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,3));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,3));
    tbl.push_back(mk(0,0,1,4'h3, 1,3,0,0,3));
    tbl.push_back(mk(0,0,1,4'h7, 2,4,1,0,4));
    tbl.push_back(mk(0,0,1,4'h5, 0,0,0,0,4));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,4));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,4));
    tbl.push_back(mk(0,1,1,4'hE, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'h3, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'h7, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,0));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,0));
    tbl.push_back(mk(0,0,1,4'h3, 1,3,0,0,0));
    tbl.push_back(mk(0,0,1,4'h7, 2,4,1,0,1));
    tbl.push_back(mk(0,0,1,4'hE, 1,1,0,0,1));
    tbl.push_back(mk(0,0,1,4'hA, 1,2,0,0,1));
    tbl.push_back(mk(1,1,1,4'h3, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'h3, 0,0,0,0,0));
    tbl.push_back(mk(0,0,1,4'h7, 0,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].v, tbl[i].sym);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].idx, tbl[i].m, tbl[i].to, tbl[i].cnt);
    end

    // Timeout after exactly TIMEOUT idle cycles.
    drive(0, 0, 1, 4'hE); drive(0, 0, 1, 4'hA);
    for (int i = 1; i < TIMEOUT; i++) begin
      drive(0, 0, 0, 4'h3);
      check_all($sformatf("idle%0d", i), 1, 2, 0, 0, 0);
    end
    drive(0, 0, 0, 4'h3);
    check_all("timeout_abort", 0, 0, 0, 1, 0);
    drive(0, 0, 0, 4'h0);
    check_all("timeout_pulse_end", 0, 0, 0, 0, 0);

    // One idle cycle short of the timeout: match still completes.
    pulses = 0;
    drive(0, 0, 1, 4'hE); drive(0, 0, 1, 4'hA);
    for (int i = 1; i < TIMEOUT; i++) begin
      drive(0, 0, 0, 4'h0);
      pulses += int'(tout);
    end
    drive(0, 0, 1, 4'h3);
    pulses += int'(tout);
    drive(0, 0, 1, 4'h7);
    check_all("near_timeout_match", 2, 4, 1, 0, 1);
    check("near_timeout_no_pulse", 32'(pulses), 32'd0);

    // Counter saturation over 300 back-to-back matches.
    drive(0, 1, 0, 4'h0);
    for (int i = 1; i <= 300; i++) begin
      send_pat();
      check($sformatf("sat_cnt%0d", i), 32'(cnt), 32'((i > 255) ? 255 : i));
    end
    check("sat_match", 32'(match), 32'd1);
    drive(0, 0, 0, 4'h0);
    check_all("sat_hold", 0, 0, 0, 0, 255);

    // Random stimulus against the model, with live pattern changes.
    drive(1, 0, 0, 4'h0);
    m_p = 0; m_idle = 0; m_cnt = 0; m_to = 0;
    vprob = 85;
    for (int n = 0; n < 4000; n++) begin
      if (n % 50 == 0) vprob = ($urandom_range(0, 2) == 0) ? 5 : 85;
      if ($urandom_range(0, 199) == 0) pattern = 16'($urandom);
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 99) < vprob);
      if ($urandom_range(0, 2) != 0)
        s = psym(pattern, (m_p > 0 && m_p < SEQ_LEN) ? m_p : 0);
      else
        s = 4'($urandom);
      model_step(r, c, v, s, pattern);
      drive(r, c, v, s);
      check($sformatf("rnd%0d", n),
            {st, 5'(idx), match, tout, cnt},
            {2'(m_p == 0 ? 0 : (m_p == SEQ_LEN ? 2 : 1)), 5'(m_p), (m_p == SEQ_LEN), m_to, 8'(m_cnt)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter SYM_W, default 4, sets the symbol width in bits (1..16).
REQ-002 Parameter SEQ_LEN, default 4, sets the pattern length in symbols (2..16).
REQ-003 Parameter TIMEOUT, default 15, sets the idle cycles without i_valid that abort a partial match (1..255).
REQ-004 Parameter CNT_W, default 8, sets the match counter width (1..32).
REQ-005 i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_clear  in  1  synchronous soft clear of state, index, timer and counter.
REQ-008 i_valid  in  1  qualifies i_sym for the current cycle.
REQ-009 i_sym  in  SYM_W  input symbol.
REQ-010 i_pattern  in  SEQ_LEN*SYM_W  target pattern; symbol k at bits [k*SYM_W +: SYM_W]; k=0 is expected first.
REQ-011 o_state  out  2  current state encoding: IDLE=0, MATCH=1, DONE=2.
REQ-012 o_idx  out  $clog2(SEQ_LEN+1)  number of pattern symbols matched so far.
REQ-013 o_match  out  1  high exactly while the state is DONE.
REQ-014 o_timeout  out  1  one-cycle pulse, the cycle after a timeout abort.
REQ-015 o_match_cnt  out  CNT_W  count of completed matches, saturating.

Function
REQ-016 The FSM SHALL be registered; all outputs SHALL be decoded from registers, with no combinational path from inputs to outputs.
REQ-017 IDLE: i_valid and i_sym==pat[0] -> MATCH with idx=1; otherwise stay in IDLE with idx=0.
REQ-018 MATCH, i_valid, i_sym==pat[idx]: idx+1; when idx+1==SEQ_LEN -> DONE with idx=SEQ_LEN.
REQ-019 MATCH, i_valid, mismatch: i_sym==pat[0] -> stay in MATCH with idx=1; otherwise -> IDLE with idx=0 (no other partial-overlap recovery).
REQ-020 MATCH, no i_valid: the idle timer increments; any i_valid clears the timer to 0.
REQ-021 When the timer reaches TIMEOUT in MATCH: -> IDLE, idx=0, timer=0, o_timeout=1 for the next cycle only.
REQ-022 The timer SHALL be held at 0 in IDLE and DONE.
REQ-023 DONE SHALL last exactly one cycle.
REQ-024 In DONE: i_valid and i_sym==pat[0] -> MATCH with idx=1; otherwise -> IDLE with idx=0.
REQ-025 Latency: a final pattern symbol accepted in cycle N gives o_match=1 in cycle N+1 only.
REQ-026 Back-to-back patterns SHALL be detected with no dead cycle.
REQ-027 o_match_cnt SHALL increment by 1 on each entry to DONE and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-028 i_pattern SHALL be compared live each cycle, not latched; a change mid-match takes effect on the next compare.
REQ-029 Encoding 3 is illegal; it SHALL go to IDLE with idx=0 on the next cycle.
REQ-030 i_clear SHALL force IDLE, idx=0, timer=0, o_match_cnt=0 and o_timeout=0 on the next cycle; it overrides all other inputs.

Reset
REQ-031 While i_rst=1 at a clock edge, the next state SHALL be: o_state=IDLE, o_idx=0, o_match=0, o_timeout=0, o_match_cnt=0, timer=0.
REQ-032 i_rst SHALL take priority over i_clear and all other inputs.
REQ-033 i_rst asserted mid-match SHALL discard the partial match; no o_match is produced for it.

Verification (SYM_W=4, SEQ_LEN=4, TIMEOUT=15, CNT_W=8, pattern E,A,3,7)
REQ-034 Valid E,A,3,7 on consecutive cycles -> o_idx 1,2,3,4; o_match=1 for exactly one cycle after the 7; o_match_cnt=1.
REQ-035 E,A,E,A,3,7 -> the mismatch at the third symbol (E) restarts with idx=1; o_match pulses once; o_match_cnt=1.
REQ-036 E,A then 15 cycles with i_valid=0 -> IDLE with idx=0; o_timeout pulses once. The same with 14 idle cycles then 3,7 -> o_match.
REQ-037 E,A,3,7,E,A,3,7 back-to-back -> two o_match pulses 4 cycles apart; o_match_cnt=2. 300 matches -> o_match_cnt holds at 255.
REQ-038 Assert i_rst, and separately i_clear, after E,A -> state IDLE, o_idx=0, o_match_cnt=0; a following 3,7 gives no o_match.
